// File: rtl/aap_fetch_stage.sv
// -----------------------------------------------------------------------------
// aap_fetch_stage
//
// Instruction fetch front end for the 16-bit AAP decoder. It holds the
// word-addressed PC, issues in-order reads to instruction memory, and buffers
// the returned words in a small FIFO. Each buffered word is tagged as either
// the first word of an instruction or the extension word of a 32-bit
// instruction. A branch redirect flushes the buffer, reloads the PC, and
// discards any read data that is still in flight.
//
// Ports
//   clock           in   1           rising-edge clock
//   reset           in   1           asynchronous, active-high
//   imem_req        out  1           read request
//   imem_addr       out  ADDR_WIDTH  read word address (== PC)
//   imem_gnt        in   1           request accepted this cycle
//   imem_rvalid     in   1           read data valid, returned in request order
//   imem_rdata      in   16          read data
//   redirect_valid  in   1           restart fetch at redirect_pc
//   redirect_pc     in   ADDR_WIDTH  new PC
//   fetch_valid     out  1           FIFO head holds a word
//   fetch_ready     in   1           decoder accepts the head word
//   fetchoutput     out  16          head instruction word
//   fetch_pc        out  ADDR_WIDTH  address of the head word
//   fetch_ext       out  1           head word is an extension word
// -----------------------------------------------------------------------------
module aap_fetch_stage #(
    parameter int                    ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [15:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [15:0]           fetchoutput,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  fetch_ext
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    // In DRAIN no new requests are issued, so the outstanding count is also
    // the number of stale responses still to be discarded.
    logic [CNT_W-1:0]      outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    // Set when the last pushed word opened a 32-bit instruction, so the next
    // pushed word is its extension.
    logic                  ext_pending_reg, ext_pending_next;

    logic [15:0]           data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic                  ext_mem  [FIFO_DEPTH];

    logic                  grant;
    logic                  resp;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        in_use;

    // Credit: every outstanding request owns a FIFO slot, so a response can
    // always be pushed without back-pressure on the memory.
    assign in_use    = {1'b0, outstanding_reg} + {1'b0, count_reg};
    assign imem_req  = (state_reg == RUN) && !redirect_valid
                       && (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr = pc_reg;

    assign grant = imem_req && imem_gnt;
    // Responses with nothing outstanding (e.g. stale data after reset) are ignored.
    assign resp  = imem_rvalid && (outstanding_reg != '0);
    // A response arriving in a redirect cycle belongs to the old stream.
    assign push  = resp && (state_reg == RUN) && !redirect_valid;
    assign pop   = fetch_valid && fetch_ready;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(resp);
        count_next       = count_reg + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        ext_pending_next = ext_pending_reg;

        if (grant) begin
            pc_next = pc_reg + ADDR_WIDTH'(1);
        end
        if (push) begin
            wr_ptr_next      = wr_ptr_reg + PTR_W'(1);
            ext_pending_next = imem_rdata[15] && !ext_pending_reg;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        case (state_reg)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect_valid && (outstanding_next != '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leaving DRAIN once nothing stale is left avoids waiting for
                // responses that will never come, even on a repeated redirect.
                if (outstanding_next == '0) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        // Redirect wins over everything else: a same-cycle pop has already
        // consumed the head word, the rest of the buffer is dropped.
        if (redirect_valid) begin
            pc_next          = redirect_pc;
            count_next       = '0;
            wr_ptr_next      = '0;
            rd_ptr_next      = '0;
            ext_pending_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            ext_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            count_reg       <= count_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            ext_pending_reg <= ext_pending_next;
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    // The PC tag is the address of the oldest outstanding request, which is
    // the current PC minus the number still in flight.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= pc_reg - ADDR_WIDTH'(outstanding_reg);
            ext_mem[wr_ptr_reg]  <= ext_pending_reg;
        end
    end

    assign fetch_valid = (count_reg != '0);
    assign fetchoutput = fetch_valid ? data_mem[rd_ptr_reg] : 16'h0000;
    assign fetch_pc    = fetch_valid ? pc_mem[rd_ptr_reg]   : '0;
    assign fetch_ext   = fetch_valid ? ext_mem[rd_ptr_reg]  : 1'b0;

    always @(posedge clock) begin
        if (!reset && push && !pop) begin
            assert (count_reg != CNT_W'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_aap_fetch_stage.sv
module tb_aap_fetch_stage;

    localparam int FD = 2;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [23:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [15:0] fetchoutput;
    logic [23:0] fetch_pc;
    logic        fetch_ext;

    aap_fetch_stage #(.ADDR_WIDTH(24), .RESET_PC(24'h0), .FIFO_DEPTH(FD)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetchoutput    (fetchoutput),
        .fetch_pc       (fetch_pc),
        .fetch_ext      (fetch_ext)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [15:0] word;
        logic        ext;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [23:0] pc;
        logic        ext;
    } hs_t;

    vec_t        vecs [8];
    bit          mem_mode;          // 0: table memory, 1: hashed memory
    logic [23:0] q [$];             // addresses granted, awaiting response
    hs_t         got [$];           // words handed to the decoder
    int          n_checks;
    int          n_fail;
    int          n_grants;

    bit          o_req, o_valid, o_ext, o_hs, o_grant;
    logic [23:0] o_addr, o_pc;
    logic [15:0] o_data;

    function automatic logic [15:0] memword(input logic [23:0] a);
        logic [31:0] h;
        if (!mem_mode) return vecs[a[2:0]].word;
        h = {8'h00, a} * 32'h9E3779B1;
        return h[31:16];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit g, input bit rv, input bit rdy, input bit rd,
                        input logic [23:0] rpc, input bit force_rv);
        hs_t h;
        @(negedge clock);
        if (rv && q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(q.pop_front());
        end else if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hDEAD;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        imem_gnt       = g;
        fetch_ready    = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        #1;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = fetch_valid;
        o_data  = fetchoutput;
        o_pc    = fetch_pc;
        o_ext   = fetch_ext;
        o_grant = imem_req && imem_gnt;
        o_hs    = fetch_valid && fetch_ready;
        if (o_grant) begin
            q.push_back(imem_addr);
            n_grants++;
        end
        if (o_hs) begin
            h.d   = fetchoutput;
            h.pc  = fetch_pc;
            h.ext = fetch_ext;
            got.push_back(h);
            $display("fetch pc=%06h word=%04h ext=%0d", h.pc, h.d, h.ext);
        end
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        q.delete();
        got.delete();
        n_grants = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] exp_pc, exp_req, tgt, p_addr;
        logic [40:0] p_word;
        logic [15:0] w;
        bit          exp_ext, g, rv, rdy, rd, p_stall, p_wait, seen;
        int          n_hs, drain_cycles;

        vecs[0] = '{16'h0001, 1'b0};
        vecs[1] = '{16'h8123, 1'b0};
        vecs[2] = '{16'h4567, 1'b1};
        vecs[3] = '{16'h0002, 1'b0};
        vecs[4] = '{16'h8000, 1'b0};
        vecs[5] = '{16'hFFFF, 1'b1};
        vecs[6] = '{16'h8001, 1'b0};
        vecs[7] = '{16'h0003, 1'b1};
        n_checks = 0;
        n_fail   = 0;
        n_grants = 0;
        mem_mode = 1'b0;

        // ---- 1: reset values, one BOOT cycle, then first request at 0
        reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 16'hFFFF;
        fetch_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 24'h0;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        chk("rst_req",   imem_req,    0);
        chk("rst_addr",  imem_addr,   0);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_data",  fetchoutput, 0);
        chk("rst_pc",    fetch_pc,    0);
        chk("rst_ext",   fetch_ext,   0);
        @(posedge clock); #1 reset = 1'b0;
        step(0, 0, 0, 0, 24'h0, 0);
        chk("boot_req", o_req, 0);
        step(0, 0, 0, 0, 24'h0, 0);
        chk("run_req",  o_req, 1);
        chk("run_addr", o_addr, 0);

        // ---- 2: streaming, table-driven words and ext tags
        do_reset();
        for (int i = 0; i < 30; i++) step(1, 1, 1, 0, 24'h0, 0);
        chk("stream_count", got.size() >= 8, 1);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk($sformatf("stream_word%0d", i), got[i].d,   vecs[i].word);
            chk($sformatf("stream_pc%0d", i),   got[i].pc,  i);
            chk($sformatf("stream_ext%0d", i),  got[i].ext, vecs[i].ext);
        end

        // ---- 3: decoder stall, credit limit, release
        do_reset();
        step(0, 0, 0, 0, 24'h0, 0);
        p_word = '0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 24'h0, 0);
            if (i == 5) p_word = {o_data, o_pc, o_ext};
            if (i > 5) chk("stall_hold", {o_data, o_pc, o_ext}, p_word);
        end
        chk("stall_grants", n_grants, FD);
        chk("stall_req",    o_req, 0);
        chk("stall_valid",  o_valid, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 24'h0, 0);
        chk("release_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("release_pc0", got[0].pc, 0);
            chk("release_d0",  got[0].d,  vecs[0].word);
            chk("release_pc1", got[1].pc, 1);
            chk("release_d1",  got[1].d,  vecs[1].word);
        end

        // ---- 4: redirect with two requests in flight
        do_reset();
        step(0, 0, 0, 0, 24'h0, 0);
        step(1, 0, 0, 0, 24'h0, 0);
        step(1, 0, 0, 0, 24'h0, 0);
        chk("drain_grants", n_grants, 2);
        step(0, 0, 1, 1, 24'h000100, 0);
        chk("redir_req", o_req, 0);
        drain_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 1, 1, 0, 24'h0, 0);
            chk("drain_valid", o_valid, 0);
            if (o_req) seen = 1'b1;
            else drain_cycles++;
        end
        chk("drain_seen",   seen, 1);
        chk("drain_cycles", drain_cycles, 2);
        chk("drain_addr",   o_addr, 24'h000100);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 24'h0, 0);
        chk("drain_got", got.size() > 0, 1);
        if (got.size() > 0) begin
            chk("drain_first_pc",  got[0].pc,  24'h000100);
            chk("drain_first_ext", got[0].ext, 0);
        end

        // ---- 5: redirect to the top of the address space, wrap to 0
        do_reset();
        step(0, 0, 0, 0, 24'h0, 0);
        step(0, 0, 1, 1, 24'hFFFFFF, 0);
        step(1, 1, 1, 0, 24'h0, 0);
        chk("wrap_req",   o_req, 1);
        chk("wrap_addr0", o_addr, 24'hFFFFFF);
        step(1, 1, 1, 0, 24'h0, 0);
        chk("wrap_addr1", o_addr, 24'h000000);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 24'h0, 0);
        chk("wrap_got", got.size() >= 2, 1);
        if (got.size() >= 2) begin
            chk("wrap_pc0",  got[0].pc,  24'hFFFFFF);
            chk("wrap_pc1",  got[1].pc,  24'h000000);
            chk("wrap_ext1", got[1].ext, 0);
        end

        // ---- 6: asynchronous reset while a word is presented
        do_reset();
        step(0, 0, 0, 0, 24'h0, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 1, 0, 0, 24'h0, 0);
            if (o_valid) seen = 1'b1;
        end
        chk("async_pre_valid", seen, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", fetch_valid, 0);
        chk("async_req",   imem_req,    0);
        chk("async_data",  fetchoutput, 0);
        q.delete();
        got.delete();
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 24'h0, 1);
            chk("late_rvalid_valid", o_valid, 0);
        end
        chk("late_req",  o_req, 1);
        chk("late_addr", o_addr, 0);

        // ---- 7: randomized traffic against an abstract stream model
        mem_mode = 1'b1;
        do_reset();
        step(0, 0, 0, 0, 24'h0, 0);
        exp_pc = 0; exp_req = 0; exp_ext = 0;
        p_stall = 0; p_wait = 0; p_addr = 0; p_word = '0;
        n_hs = 0;
        for (int c = 0; c < 3000; c++) begin
            g   = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 99) < 3);
            tgt = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE + 24'($urandom_range(0, 1))
                                              : 24'($urandom);
            step(g, rv, rdy, rd, tgt, 0);
            if (p_stall) begin
                chk("rand_stall_valid", o_valid, 1);
                chk("rand_stall_word",  {o_data, o_pc, o_ext}, p_word);
            end
            if (p_wait && !rd) begin
                chk("rand_req_hold",  o_req,  1);
                chk("rand_addr_hold", o_addr, p_addr);
            end
            if (o_grant) begin
                chk("rand_req_addr", o_addr, exp_req);
                exp_req = exp_req + 24'd1;
            end
            if (o_hs) begin
                w = memword(exp_pc);
                chk("rand_word", {o_data, o_pc, o_ext}, {w, exp_pc, exp_ext});
                exp_ext = w[15] && !exp_ext;
                exp_pc  = exp_pc + 24'd1;
                n_hs++;
            end
            if (rd) begin
                chk("rand_redir_req", o_req, 0);
                exp_pc  = tgt;
                exp_req = tgt;
                exp_ext = 1'b0;
            end
            chk("rand_credit", q.size() <= FD, 1);
            p_stall = o_valid && !rdy && !rd;
            p_word  = {o_data, o_pc, o_ext};
            p_wait  = o_req && !g && !rd;
            p_addr  = o_addr;
        end
        chk("rand_progress", n_hs > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
